pcfx_bkram_ctrl: RTL and testbench

- Sequences backup-RAM image transfers between the HPS sector interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) and the core's internal backup RAM port.
- Handles auto-load on image mount, plus OSD-triggered load and save.
- Produces bk_ena for the OSD menu mask.
- Sits inside pcfx_top, between the hps_io sector signals and the backup RAM block.

---
 rtl/pcfx_bkram_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pcfx_bkram_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcfx_bkram_ctrl.sv
// Backup-RAM image sequencer: moves whole 512-byte sectors between the HPS
// sector interface and the internal backup RAM. Handles auto-load on mount,
// OSD load/save requests, and the ack timeout.
module pcfx_bkram_ctrl #(
  parameter int BK_SECTORS  = 64,
  parameter int AW          = 14,
  parameter int ACK_TIMEOUT = 2**24
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          img_mounted,
  input  logic          img_readonly,
  input  logic [63:0]   img_size,
  input  logic          bk_load,
  input  logic          bk_save,
  output logic [31:0]   sd_lba,
  output logic          sd_rd,
  output logic          sd_wr,
  input  logic          sd_ack,
  input  logic [7:0]    sd_buff_addr,
  input  logic [15:0]   sd_buff_dout,
  input  logic          sd_buff_wr,
  output logic [15:0]   sd_buff_din,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_wdata,
  output logic          ram_we,
  input  logic [15:0]   ram_rdata,
  output logic          bk_ena,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int SW = AW - 8;          // sector index width
  localparam int NW = SW + 1;          // sector count width (holds BK_SECTORS)
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [54:0]   BK_SEC   = 55'(BK_SECTORS);
  localparam logic [NW-1:0] BK_SEC_N = NW'(BK_SECTORS);
  localparam logic [TW-1:0] T_LAST   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_NEXT} state_t;

  state_t          r_state, w_nxt;
  logic            r_mounted, r_ro, r_auto, r_dir, r_done, r_err;
  logic            r_load_d, r_save_d, r_we;
  logic [NW-1:0]   r_nsec;
  logic [SW-1:0]   r_sec;
  logic [TW-1:0]   r_timer;
  logic [AW-1:0]   r_waddr;
  logic [15:0]     r_wdata;

  logic            w_busy, w_big, w_load_edge, w_save_edge;
  logic            w_start, w_start_dir, w_take_auto, w_timeout, w_fin, w_adv;
  logic [NW-1:0]   w_nsec, w_sec_inc;

  assign w_busy      = (r_state != S_IDLE);
  assign w_big       = (img_size >= 64'd512);
  // Images larger than the backup RAM are clipped to BK_SECTORS.
  assign w_nsec      = (img_size[63:9] >= BK_SEC) ? BK_SEC_N : img_size[9+NW-1:9];
  assign w_load_edge = bk_load & ~r_load_d;
  assign w_save_edge = bk_save & ~r_save_d;
  assign w_sec_inc   = {1'b0, r_sec} + NW'(1);

  // Next-state logic: request arbitration in IDLE, ack handshake and timeout
  always_comb begin
    w_nxt       = r_state;
    w_start     = 1'b0;
    w_start_dir = 1'b0;
    w_take_auto = 1'b0;
    w_timeout   = 1'b0;
    w_fin       = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_auto) begin
          w_start     = 1'b1;
          w_take_auto = 1'b1;
        end else if (w_load_edge && r_mounted) begin
          w_start = 1'b1;
        end else if (w_save_edge && r_mounted && !r_ro) begin
          w_start     = 1'b1;
          w_start_dir = 1'b1;
        end
        if (w_start) w_nxt = S_REQ;
      end
      S_REQ: begin
        if (sd_ack) begin
          w_nxt = S_XFER;
        end else if (r_timer == T_LAST) begin
          w_nxt     = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      // XFER is entered with sd_ack high, so a low level marks its falling edge
      S_XFER: if (!sd_ack) w_nxt = S_NEXT;
      S_NEXT: begin
        if (w_sec_inc == r_nsec) begin
          w_nxt = S_IDLE;
          w_fin = 1'b1;
        end else begin
          w_nxt = S_REQ;
          w_adv = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // Mount tracking, pending auto-load, error flag and request edge detectors
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mounted <= 1'b0;
      r_ro      <= 1'b0;
      r_nsec    <= '0;
      r_auto    <= 1'b0;
      r_err     <= 1'b0;
      r_load_d  <= 1'b0;
      r_save_d  <= 1'b0;
    end else begin
      r_load_d <= bk_load;
      r_save_d <= bk_save;
      if (img_mounted) begin
        r_mounted <= w_big;
        r_ro      <= img_readonly;
        r_nsec    <= w_nsec;
        r_auto    <= w_big;     // an unmount discards any pending auto-load
        r_err     <= 1'b0;
      end else begin
        if (w_take_auto) r_auto <= 1'b0;
        if (w_timeout)   r_err  <= 1'b1;
      end
    end
  end

  // Sector counter, direction, ack timer and completion pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sec   <= '0;
      r_dir   <= 1'b0;
      r_timer <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_start) begin
        r_sec <= '0;
        r_dir <= w_start_dir;
      end else if (w_adv) begin
        r_sec <= r_sec + SW'(1);
      end
      if (w_start || w_adv)     r_timer <= '0;
      else if (r_state == S_REQ) r_timer <= r_timer + TW'(1);
    end
  end

  // Load path: one registered RAM write per HPS buffer strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_busy & ~r_dir & sd_ack & sd_buff_wr;
      if (sd_buff_wr) begin
        r_waddr <= {r_sec, sd_buff_addr};
        r_wdata <= sd_buff_dout;
      end
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign bk_ena      = r_mounted;
  assign sd_lba      = w_busy ? 32'(r_sec) : 32'd0;
  assign sd_rd       = (r_state == S_REQ) & ~r_dir;
  assign sd_wr       = (r_state == S_REQ) & r_dir;
  assign ram_we      = r_we;
  assign ram_wdata   = r_wdata;
  // Save path: HPS buffer index drives the RAM address directly, and the
  // 1-cycle RAM latency lines up with the HPS buffer read timing.
  assign ram_addr    = r_we ? r_waddr : (w_busy & r_dir) ? {r_sec, sd_buff_addr} : '0;
  assign sd_buff_din = (w_busy & r_dir) ? ram_rdata : 16'h0000;
endmodule

// File: tb/tb_pcfx_bkram_ctrl.sv
// Bench for pcfx_bkram_ctrl: HPS sector model, backup RAM model, scoreboard
// of HPS strobes vs RAM writes, and a sector-level reference model.
module tb_pcfx_bkram_ctrl;
  localparam int BK = 64, AW = 14, TO = 1000, WORDS = BK * 256;

  logic          clk_sys = 1'b0, reset_n = 1'b0;
  logic          img_mounted = 1'b0, img_readonly = 1'b0;
  logic [63:0]   img_size = '0;
  logic          bk_load = 1'b0, bk_save = 1'b0;
  logic [31:0]   sd_lba;
  logic          sd_rd, sd_wr;
  logic          sd_ack = 1'b0;
  logic [7:0]    sd_buff_addr = '0;
  logic [15:0]   sd_buff_dout = '0;
  logic          sd_buff_wr = 1'b0;
  logic [15:0]   sd_buff_din;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic          ram_we;
  logic [15:0]   ram_rdata = '0;
  logic          bk_ena, busy, done, err;

  always #5 clk_sys = ~clk_sys;

  pcfx_bkram_ctrl #(.BK_SECTORS(BK), .AW(AW), .ACK_TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size(img_size), .bk_load(bk_load),
    .bk_save(bk_save), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .bk_ena(bk_ena), .busy(busy), .done(done), .err(err)
  );

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0;
  logic [15:0] mem     [WORDS];
  logic [15:0] exp_mem [WORDS];
  logic [15:0] salt = '0;
  logic        exp_mnt = 1'b0, hps_mute = 1'b0, hps_dir = 1'b0;
  logic        hps_active = 1'b0, rst_test = 1'b0, preload = 1'b0;
  logic [29:0] sb[$];
  logic [32:0] lba_log[$];
  logic [32:0] exp_lba[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int k, input int w, input logic [15:0] s);
    return {k[7:0], w[7:0]} ^ s;
  endfunction

  function automatic int nsec_of(input logic [63:0] sz);
    longint n = longint'(sz / 512);
    return (n > BK) ? BK : int'(n);
  endfunction

  // Backup RAM model: 1-cycle read latency, optional address-pattern preload
  always @(posedge clk_sys) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 16'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // HPS sector model: answers sd_rd with strobed data, sd_wr by reading sd_buff_din
  initial begin : hps
    int  k;
    logic wr;
    forever begin
      @(negedge clk_sys);
      if (reset_n && !hps_mute && (sd_rd || sd_wr)) begin
        k = int'(sd_lba); wr = sd_wr; hps_dir = wr; hps_active = 1'b1;
        lba_log.push_back({wr, sd_lba});
        repeat ($urandom_range(0, 3)) @(posedge clk_sys);
        @(posedge clk_sys); #1 sd_ack = 1'b1;
        for (int w = 0; w < 256; w++) begin
          if (wr) begin
            sd_buff_addr = 8'(w);
            @(posedge clk_sys); #1;
            check("save_din", sd_buff_din, exp_mem[(k * 256 + w) % WORDS]);
          end else begin
            if ($urandom_range(0, 7) == 0) begin @(posedge clk_sys); #1; end
            sd_buff_addr = 8'(w);
            sd_buff_dout = pat(k, w, salt);
            sd_buff_wr   = 1'b1;
            if (!rst_test) sb.push_back({AW'(k * 256 + w), sd_buff_dout});
            @(posedge clk_sys); #1 sd_buff_wr = 1'b0;
          end
        end
        sd_ack = 1'b0; hps_active = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin : cmp
    logic [29:0] e;
    forever begin
      @(negedge clk_sys);
      if (done) done_cnt++;
      check("bk_ena", bk_ena, exp_mnt);
      if (!busy) check("idle_quiet", {ram_we, ram_addr, sd_rd, sd_wr}, '0);
      if (ram_we) begin
        if (rst_test || hps_dir) check("ram_we_forbidden", ram_we, 1'b0);
        else if (sb.size() == 0) check("ram_we_unmatched", ram_we, 1'b0);
        else begin
          e = sb.pop_front();
          check("ram_write", {ram_addr, ram_wdata}, e);
        end
      end
      if (rst_test) sb.delete();
    end
  end

  task automatic mount(input logic [63:0] sz, input logic ro);
    @(posedge clk_sys); #1 img_size = sz; img_readonly = ro; img_mounted = 1'b1;
    @(posedge clk_sys); #1 img_mounted = 1'b0; exp_mnt = (sz >= 64'd512);
  endtask

  task automatic pulse(input logic ld, input logic sv);
    @(posedge clk_sys); #1 bk_load = ld; bk_save = sv;
    repeat (3) @(posedge clk_sys); #1 bk_load = 1'b0; bk_save = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input int maxc, input string name);
    int c = 0;
    while (done_cnt < tgt && c < maxc) begin @(negedge clk_sys); c++; end
    repeat (4) @(negedge clk_sys);
    check(name, done_cnt, tgt);
  endtask

  task automatic quiet(input int n, input string name);
    int b = 0;
    repeat (n) begin @(negedge clk_sys); if (busy || sd_rd || sd_wr) b++; end
    check(name, b, 0);
  endtask

  // Reference model of a completed load/save at sector granularity
  task automatic exp_load(input int n);
    for (int k = 0; k < n; k++) begin
      exp_lba.push_back({1'b0, 32'(k)});
      for (int w = 0; w < 256; w++) exp_mem[k * 256 + w] = pat(k, w, salt);
    end
  endtask

  task automatic exp_save(input int n);
    for (int k = 0; k < n; k++) exp_lba.push_back({1'b1, 32'(k)});
  endtask

  task automatic chk_log(input string name);
    int m = 0;
    check({name, "_len"}, lba_log.size(), exp_lba.size());
    for (int i = 0; i < lba_log.size() && i < exp_lba.size(); i++)
      if (lba_log[i] !== exp_lba[i]) m++;
    check(name, m, 0);
    lba_log.delete(); exp_lba.delete();
  endtask

  task automatic chk_mem(input string name);
    int m = 0, first = -1;
    for (int i = 0; i < WORDS; i++)
      if (mem[i] !== exp_mem[i]) begin m++; if (first < 0) first = i; end
    if (m != 0) $display("  first bad word %0h: got %0h expected %0h", first, mem[first], exp_mem[first]);
    check(name, m, 0);
  endtask

  initial begin : main
    int c, d0;
    for (int i = 0; i < WORDS; i++) exp_mem[i] = '0;
    #1;
    check("rst_ctl", {sd_rd, sd_wr, busy, done, err, ram_we, bk_ena}, '0);
    check("rst_lba", sd_lba, 0);
    check("rst_ram", {ram_addr, ram_wdata, sd_buff_din}, '0);
    repeat (3) @(posedge clk_sys); #1 reset_n = 1'b1;
    preload = 1'b1; @(posedge clk_sys); #1 preload = 1'b0;
    for (int i = 0; i < WORDS; i++) exp_mem[i] = 16'(i);

    // 1: auto-load of a full 32 KiB image, pattern {sector, word}
    d0 = done_cnt; salt = '0;
    mount(64'd32768, 1'b0);
    wait_done(d0 + 1, 40000, "autoload_done");
    exp_load(nsec_of(64'd32768));
    chk_log("autoload_lba");
    chk_mem("autoload_mem");
    check("autoload_lit0", mem[3 * 256 + 5], 16'h0305);
    check("autoload_lit1", mem[WORDS - 1], 16'h3FFF);
    check("autoload_err", {err, bk_ena}, 2'b01);
    check("autoload_sb", sb.size(), 0);

    // 2: save of address-pattern RAM
    preload = 1'b1; @(posedge clk_sys); #1 preload = 1'b0;
    for (int i = 0; i < WORDS; i++) exp_mem[i] = 16'(i);
    d0 = done_cnt;
    pulse(1'b0, 1'b1);
    wait_done(d0 + 1, 40000, "save_done");
    exp_save(BK);
    chk_log("save_lba");
    chk_mem("save_ram_untouched");

    // 3a: read-only image auto-loads but refuses save
    d0 = done_cnt; salt = 16'($urandom);
    mount(64'd32768, 1'b1);
    wait_done(d0 + 1, 40000, "ro_autoload_done");
    exp_load(BK);
    chk_log("ro_autoload_lba");
    pulse(1'b0, 1'b1);
    quiet(30, "ro_save_dropped");
    chk_log("ro_save_lba");

    // 3b: 1 KiB image transfers only sectors 0 and 1
    d0 = done_cnt; salt = 16'hA5A5;
    mount(64'd1024, 1'b0);
    wait_done(d0 + 1, 5000, "short_autoload_done");
    exp_load(nsec_of(64'd1024));
    chk_log("short_autoload_lba");
    chk_mem("short_autoload_mem");
    check("short_lit", mem[1 * 256 + 2], 16'hA4A7);
    d0 = done_cnt; salt = 16'($urandom);
    pulse(1'b1, 1'b0);
    wait_done(d0 + 1, 5000, "short_load_done");
    exp_load(2);
    chk_log("short_load_lba");
    chk_mem("short_load_mem");

    // 3c: undersized image is not a valid mount
    mount(64'd100, 1'b0);
    check("tiny_bk_ena", bk_ena, 1'b0);
    pulse(1'b1, 1'b1);
    quiet(30, "tiny_no_xfer");
    chk_log("tiny_lba");

    // 4: ack timeout
    d0 = done_cnt; hps_mute = 1'b1;
    mount(64'd1024, 1'b0);
    c = 0;
    while (!sd_rd && c < 20) begin @(negedge clk_sys); c++; end
    check("to_rd_seen", sd_rd, 1'b1);
    repeat (TO - 1) @(negedge clk_sys);
    check("to_before", {err, sd_rd, busy}, 3'b011);
    @(negedge clk_sys);
    check("to_after", {err, sd_rd, busy}, 3'b100);
    check("to_no_done", done_cnt, d0);
    hps_mute = 1'b0;
    mount(64'd100, 1'b0);
    check("to_err_cleared", err, 1'b0);
    chk_log("to_lba");

    // 5a: simultaneous load and save edges -> load only
    d0 = done_cnt; salt = 16'($urandom);
    mount(64'd1024, 1'b0);
    wait_done(d0 + 1, 5000, "sim_auto_done");
    exp_load(2);
    chk_log("sim_auto_lba");
    d0 = done_cnt; salt = 16'($urandom);
    pulse(1'b1, 1'b1);
    wait_done(d0 + 1, 5000, "sim_load_done");
    exp_load(2);
    quiet(20, "sim_save_dropped");
    chk_log("sim_lba");
    chk_mem("sim_mem");

    // 5b: remount during save -> save completes, then auto-load
    d0 = done_cnt;
    pulse(1'b0, 1'b1);
    c = 0;
    while (lba_log.size() == 0 && c < 100) begin @(negedge clk_sys); c++; end
    salt = 16'($urandom);
    mount(64'd1024, 1'b0);
    wait_done(d0 + 2, 6000, "remount_done");
    exp_save(2);
    exp_load(2);
    chk_log("remount_lba");
    chk_mem("remount_mem");

    // 6: asynchronous reset in the middle of a load sector
    salt = 16'($urandom);
    pulse(1'b1, 1'b0);
    c = 0;
    while (!sd_ack && c < 100) begin @(negedge clk_sys); c++; end
    check("rst_mid_ack", sd_ack, 1'b1);
    repeat (40) @(posedge clk_sys);
    #3 rst_test = 1'b1; reset_n = 1'b0; exp_mnt = 1'b0;
    #1;
    check("rst_mid_ctl", {sd_rd, sd_wr, busy, done, err, ram_we, bk_ena}, '0);
    check("rst_mid_bus", {sd_lba, ram_addr, sd_buff_din}, '0);
    repeat (5) @(posedge clk_sys); #1 reset_n = 1'b1;
    c = 0;
    while (hps_active && c < 1000) begin @(negedge clk_sys); c++; end
    check("rst_hps_drained", hps_active, 1'b0);
    repeat (5) @(negedge clk_sys);
    rst_test = 1'b0;
    check("rst_idle", {busy, bk_ena, err}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
